// File: rtl/mem_bridge_pkg.sv
// Shared types and helpers for the pixel-to-memory burst bridge.
// Holds the FSM state encoding, the burst ceiling and the beat-to-byte address shift.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    DONE
  } state_e;

  localparam int MAX_BURST = 256;

  // Number of bits a word address must move left to become a byte address.
  function automatic int addr_shift(input int mem_data_len);
    return $clog2(mem_data_len / 8);
  endfunction

endpackage

// File: rtl/burst_watchdog.sv
// Stall counter for the burst bridge; only present when MEM_BURST_TIMEOUT_EN is defined.
// Fires once TIMEOUT_CYC consecutive cycles pass in an active state without any handshake.
`ifdef MEM_BURST_TIMEOUT_EN
module burst_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic kick,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (!active || kick) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
      // This cycle is the TIMEOUT_CYC-th stalled one.
      timeout = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/mem_burst_bridge.sv
// Arbitrates pixel-side read/write burst requests onto an AXI-style memory port.
// Define MEM_BURST_TIMEOUT_EN to abort bursts that stall for TIMEOUT_CYC cycles.
module mem_burst_bridge
  import mem_bridge_pkg::*;
#(
  parameter int MEM_DATA_LEN = 64,
  parameter int ADDR_LEN     = 32,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  // pixel-side read
  input  logic                    rd_valid,
  input  logic [9:0]              rd_burst_len,
  input  logic [ADDR_LEN-1:0]     rd_addr,
  output logic                    rd_ready,
  output logic [MEM_DATA_LEN-1:0] rd_data,
  output logic                    rd_burst_finish,
  // pixel-side write
  input  logic                    wr_valid,
  input  logic [9:0]              wr_burst_len,
  input  logic [ADDR_LEN-1:0]     wr_addr,
  input  logic [MEM_DATA_LEN-1:0] wr_data,
  output logic                    wr_ready,
  output logic                    wr_burst_finish,
  // memory read
  output logic [ADDR_LEN-1:0]     m_araddr,
  output logic [7:0]              m_arlen,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [MEM_DATA_LEN-1:0] m_rdata,
  input  logic                    m_rvalid,
  input  logic                    m_rlast,
  output logic                    m_rready,
  // memory write
  output logic [ADDR_LEN-1:0]     m_awaddr,
  output logic [7:0]              m_awlen,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [MEM_DATA_LEN-1:0] m_wdata,
  output logic                    m_wvalid,
  output logic                    m_wlast,
  input  logic                    m_wready,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic                    error
);

  localparam int SHIFT = addr_shift(MEM_DATA_LEN);

  if (TIMEOUT_CYC < 1) begin : g_timeout_range_check
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [8:0]          len_q, len_d;
  logic [8:0]          beat_q, beat_d;
  logic                is_wr_q, is_wr_d;
  logic                prio_wr_q, prio_wr_d;
  logic                error_q, error_d;

  logic                grant_wr;
  logic [9:0]          req_len;
  logic [ADDR_LEN-1:0] req_addr;
  logic                len_over;
  logic [8:0]          eff_len;
  logic [8:0]          beat_inc;
  logic                timeout;

  // Data paths are pure pass-through; qualification is done by the strobes.
  assign rd_data  = m_rdata;
  assign m_wdata  = wr_data;
  assign m_araddr = addr_q;
  assign m_awaddr = addr_q;
  assign m_arlen  = 8'(len_q - 9'd1);
  assign m_awlen  = 8'(len_q - 9'd1);
  assign error    = error_q;
  assign beat_inc = beat_q + 9'd1;

  // Round-robin: on contention the side not served last wins.
  always_comb begin
    grant_wr = wr_valid && (!rd_valid || prio_wr_q);
    req_len  = grant_wr ? wr_burst_len : rd_burst_len;
    req_addr = grant_wr ? wr_addr : rd_addr;
    len_over = req_len > 10'(MAX_BURST);
    if (req_len == 10'd0) begin
      eff_len = 9'd1;
    end else if (len_over) begin
      eff_len = 9'(MAX_BURST);
    end else begin
      eff_len = req_len[8:0];
    end
  end

  always_comb begin
    m_arvalid       = 1'b0;
    m_rready        = 1'b0;
    rd_ready        = 1'b0;
    m_awvalid       = 1'b0;
    m_wvalid        = 1'b0;
    m_wlast         = 1'b0;
    wr_ready        = 1'b0;
    m_bready        = 1'b0;
    rd_burst_finish = 1'b0;
    wr_burst_finish = 1'b0;
    unique case (state_q)
      RD_ADDR: m_arvalid = 1'b1;
      RD_DATA: begin
        m_rready = 1'b1;
        rd_ready = m_rvalid;
      end
      WR_ADDR: m_awvalid = 1'b1;
      WR_DATA: begin
        m_wvalid = 1'b1;
        wr_ready = m_wready;
        m_wlast  = (beat_q == len_q - 9'd1);
      end
      WR_RESP: m_bready = 1'b1;
      DONE: begin
        rd_burst_finish = !is_wr_q;
        wr_burst_finish = is_wr_q;
      end
      default: ;
    endcase
  end

`ifdef MEM_BURST_TIMEOUT_EN
  logic wd_active;
  logic wd_kick;

  assign wd_active = (state_q != IDLE) && (state_q != DONE);
  assign wd_kick   = (m_arvalid && m_arready) || (m_rready && m_rvalid) ||
                     (m_awvalid && m_awready) || (m_wvalid && m_wready) ||
                     (m_bready && m_bvalid);

  burst_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (wd_active),
    .kick   (wd_kick),
    .timeout(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    is_wr_d   = is_wr_q;
    prio_wr_d = prio_wr_q;
    error_d   = error_q;
    unique case (state_q)
      IDLE: begin
        if (rd_valid || wr_valid) begin
          is_wr_d   = grant_wr;
          prio_wr_d = !grant_wr;
          addr_d    = req_addr << SHIFT;
          len_d     = eff_len;
          beat_d    = '0;
          if (len_over) begin
            error_d = 1'b1;
          end
          state_d = grant_wr ? WR_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (m_arready) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_rvalid) begin
          beat_d = beat_inc;
          // Stop on whichever comes first; disagreement means the memory and we differ on length.
          if ((beat_inc == len_q) || m_rlast) begin
            state_d = DONE;
          end
          if ((beat_inc == len_q) != m_rlast) begin
            error_d = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        if (m_awready) begin
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (m_wready) begin
          beat_d = beat_inc;
          if (beat_inc == len_q) begin
            state_d = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (m_bvalid) begin
          state_d = DONE;
        end
      end
      DONE: begin
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = DONE;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= 9'd1;
      beat_q    <= '0;
      is_wr_q   <= 1'b0;
      prio_wr_q <= 1'b1;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      is_wr_q   <= is_wr_d;
      prio_wr_q <= prio_wr_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_bridge.sv
// Directed bench for mem_burst_bridge: a per-cycle read vector table plus
// hand-written write, arbitration, early-rlast, stall/timeout and mid-burst reset sequences.
module tb_mem_burst_bridge;
  import mem_bridge_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_valid, rd_ready, rd_burst_finish;
  logic [9:0]    rd_burst_len;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_valid, wr_ready, wr_burst_finish;
  logic [9:0]    wr_burst_len;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] m_araddr, m_awaddr;
  logic [7:0]    m_arlen, m_awlen;
  logic          m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
  logic [DW-1:0] m_rdata, m_wdata;
  logic          m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic          error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_burst_bridge #(
    .MEM_DATA_LEN(DW),
    .ADDR_LEN    (AW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rd_valid       (rd_valid),
    .rd_burst_len   (rd_burst_len),
    .rd_addr        (rd_addr),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .rd_burst_finish(rd_burst_finish),
    .wr_valid       (wr_valid),
    .wr_burst_len   (wr_burst_len),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .wr_burst_finish(wr_burst_finish),
    .m_araddr       (m_araddr),
    .m_arlen        (m_arlen),
    .m_arvalid      (m_arvalid),
    .m_arready      (m_arready),
    .m_rdata        (m_rdata),
    .m_rvalid       (m_rvalid),
    .m_rlast        (m_rlast),
    .m_rready       (m_rready),
    .m_awaddr       (m_awaddr),
    .m_awlen        (m_awlen),
    .m_awvalid      (m_awvalid),
    .m_awready      (m_awready),
    .m_wdata        (m_wdata),
    .m_wvalid       (m_wvalid),
    .m_wlast        (m_wlast),
    .m_wready       (m_wready),
    .m_bvalid       (m_bvalid),
    .m_bready       (m_bready),
    .error          (error)
  );

  typedef struct {
    logic        rd_valid;
    logic [9:0]  rd_len;
    logic [31:0] rd_addr;
    logic        arready;
    logic        rvalid;
    logic        rlast;
    logic [63:0] rdata;
    logic        e_arvalid;
    logic [31:0] e_araddr;
    logic [7:0]  e_arlen;
    logic        e_rready;
    logic        e_rd_ready;
    logic        e_finish;
    logic        e_error;
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl[NVEC];

  function automatic vec_t mkv(input logic rv, input logic [9:0] len, input logic [31:0] addr,
                               input logic ar, input logic rvld, input logic rl,
                               input logic [63:0] rd, input logic eav, input logic [31:0] eaddr,
                               input logic [7:0] elen, input logic erdy, input logic erd,
                               input logic efin, input logic eerr);
    vec_t v;
    v.rd_valid = rv;   v.rd_len = len;     v.rd_addr = addr;
    v.arready = ar;    v.rvalid = rvld;    v.rlast = rl;     v.rdata = rd;
    v.e_arvalid = eav; v.e_araddr = eaddr; v.e_arlen = elen;
    v.e_rready = erdy; v.e_rd_ready = erd; v.e_finish = efin; v.e_error = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_valid = 1'b0; rd_burst_len = '0; rd_addr = '0;
    wr_valid = 1'b0; wr_burst_len = '0; wr_addr = '0; wr_data = '0;
    m_arready = 1'b0; m_rdata = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, ".outs"}, {m_arvalid, m_awvalid, m_rready, m_wvalid, m_wlast, m_bready,
                          rd_ready, wr_ready, rd_burst_finish, wr_burst_finish, error}, 64'h0);
    chk({name, ".state"}, 64'(dut.state_q), 64'(IDLE));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int  pulses, k, n;
    logic rd_done, wr_done, found, err_at_fin;

    tbl[0]  = mkv(1, 10'd1,   32'h10,  1, 0, 0, 64'h0,                  0, 32'h0,   8'h00, 0, 0, 0, 0);
    tbl[1]  = mkv(0, 10'd7,   32'h55,  1, 0, 0, 64'h0,                  1, 32'h80,  8'h00, 0, 0, 0, 0);
    tbl[2]  = mkv(0, 10'd0,   32'h0,   0, 1, 1, 64'hDEADBEEF_CAFEF00D,  0, 32'h0,   8'h00, 1, 1, 0, 0);
    tbl[3]  = mkv(0, 10'd0,   32'h0,   0, 0, 0, 64'h0,                  0, 32'h0,   8'h00, 0, 0, 1, 0);
    tbl[4]  = mkv(1, 10'd0,   32'h1,   0, 0, 0, 64'h0,                  0, 32'h0,   8'h00, 0, 0, 0, 0);
    tbl[5]  = mkv(0, 10'd3,   32'h2,   0, 0, 0, 64'h0,                  1, 32'h8,   8'h00, 0, 0, 0, 0);
    tbl[6]  = mkv(0, 10'd0,   32'h0,   1, 0, 0, 64'h0,                  1, 32'h8,   8'h00, 0, 0, 0, 0);
    tbl[7]  = mkv(0, 10'd0,   32'h0,   0, 0, 0, 64'h0,                  0, 32'h0,   8'h00, 1, 0, 0, 0);
    tbl[8]  = mkv(0, 10'd0,   32'h0,   0, 1, 1, 64'h01234567_89ABCDEF,  0, 32'h0,   8'h00, 1, 1, 0, 0);
    tbl[9]  = mkv(0, 10'd0,   32'h0,   0, 0, 0, 64'h0,                  0, 32'h0,   8'h00, 0, 0, 1, 0);
    tbl[10] = mkv(1, 10'd300, 32'h100, 0, 0, 0, 64'h0,                  0, 32'h0,   8'h00, 0, 0, 0, 0);
    tbl[11] = mkv(0, 10'd0,   32'h0,   0, 0, 0, 64'h0,                  1, 32'h800, 8'hFF, 0, 0, 0, 1);
    tbl[12] = mkv(0, 10'd0,   32'h0,   0, 0, 0, 64'h0,                  1, 32'h800, 8'hFF, 0, 0, 0, 1);

    // Reset state
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk_quiet("reset");
    $display("[TB] reset state checked");
    do_reset();

    // Read vector table: single-beat, len 0, stalls, clamp of len 300
    for (int i = 0; i < NVEC; i++) begin
      rd_valid = tbl[i].rd_valid; rd_burst_len = tbl[i].rd_len; rd_addr = tbl[i].rd_addr;
      m_arready = tbl[i].arready; m_rvalid = tbl[i].rvalid; m_rlast = tbl[i].rlast;
      m_rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d.arvalid", i), m_arvalid, tbl[i].e_arvalid);
      if (tbl[i].e_arvalid) begin
        chk($sformatf("vec%0d.araddr", i), m_araddr, tbl[i].e_araddr);
        chk($sformatf("vec%0d.arlen", i), m_arlen, tbl[i].e_arlen);
      end
      chk($sformatf("vec%0d.rready", i), m_rready, tbl[i].e_rready);
      chk($sformatf("vec%0d.rd_ready", i), rd_ready, tbl[i].e_rd_ready);
      if (tbl[i].e_rd_ready) chk($sformatf("vec%0d.rd_data", i), rd_data, tbl[i].rdata);
      chk($sformatf("vec%0d.rd_finish", i), rd_burst_finish, tbl[i].e_finish);
      chk($sformatf("vec%0d.wr_finish", i), wr_burst_finish, 1'b0);
      chk($sformatf("vec%0d.error", i), error, tbl[i].e_error);
      $display("[TB] vec %0d rd_valid=%0d len=%0d addr=0x%0h", i, tbl[i].rd_valid,
               tbl[i].rd_len, tbl[i].rd_addr);
      next_cycle();
    end

    // Write len 4 at 0x1FA400 with m_wready toggling
    do_reset();
    wr_valid = 1'b1; wr_burst_len = 10'd4; wr_addr = 32'h1FA400; m_awready = 1'b1;
    @(negedge clk);
    chk("wr.idle_awvalid", m_awvalid, 1'b0);
    next_cycle();
    wr_valid = 1'b0; wr_burst_len = 10'd9; wr_addr = 32'h0;
    @(negedge clk);
    chk("wr.awvalid", m_awvalid, 1'b1);
    chk("wr.awaddr", m_awaddr, 32'h00FD2000);
    chk("wr.awlen", m_awlen, 8'd3);
    next_cycle();
    pulses = 0;
    for (int g = 0; g < 20 && pulses < 4; g++) begin
      m_wready = (g % 2 == 1);
      wr_data  = 64'hA000 + 64'(g);
      @(negedge clk);
      chk("wr.wvalid", m_wvalid, 1'b1);
      chk("wr.wr_ready", wr_ready, m_wready);
      chk("wr.wdata", m_wdata, 64'hA000 + 64'(g));
      if (m_wready) begin
        pulses++;
        chk($sformatf("wr.wlast_beat%0d", pulses), m_wlast, (pulses == 4));
      end
      next_cycle();
    end
    chk("wr.beats", 64'(pulses), 64'd4);
    m_wready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      chk("wr.bready", m_bready, 1'b1);
      chk("wr.early_finish", wr_burst_finish, 1'b0);
      next_cycle();
    end
    m_bvalid = 1'b1;
    @(negedge clk);
    chk("wr.bready_hs", m_bready, 1'b1);
    next_cycle();
    m_bvalid = 1'b0;
    @(negedge clk);
    chk("wr.finish", wr_burst_finish, 1'b1);
    chk("wr.no_rd_finish", rd_burst_finish, 1'b0);
    next_cycle();
    @(negedge clk);
    chk_quiet("wr.after");
    $display("[TB] write burst len 4 done, %0d beats", pulses);
    next_cycle();

    // Simultaneous requests from reset: write first, then read
    do_reset();
    rd_valid = 1'b1; rd_burst_len = 10'd1; rd_addr = 32'h40;
    wr_valid = 1'b1; wr_burst_len = 10'd1; wr_addr = 32'h80;
    m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    rd_done = 1'b0; wr_done = 1'b0;
    for (int c = 0; c < 40 && !(rd_done && wr_done); c++) begin
      @(negedge clk);
      chk("arb.dual_finish", rd_burst_finish & wr_burst_finish, 1'b0);
      if (wr_burst_finish && !wr_done) begin
        chk("arb.write_first", rd_done, 1'b0);
        wr_done = 1'b1;
      end
      if (rd_burst_finish) rd_done = 1'b1;
      next_cycle();
      if (wr_done) wr_valid = 1'b0;
      if (rd_done) rd_valid = 1'b0;
    end
    chk("arb.wr_served", wr_done, 1'b1);
    chk("arb.rd_served", rd_done, 1'b1);
    chk("arb.error", error, 1'b0);
    $display("[TB] arbitration wr_done=%0d rd_done=%0d", wr_done, rd_done);

    // Read len 4 with m_rlast on beat 3
    do_reset();
    rd_valid = 1'b1; rd_burst_len = 10'd4; rd_addr = 32'h20; m_arready = 1'b1;
    next_cycle();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("rlast.arlen", m_arlen, 8'd3);
    next_cycle();
    for (int b = 1; b <= 3; b++) begin
      m_rvalid = 1'b1; m_rlast = (b == 3); m_rdata = 64'(b);
      @(negedge clk);
      chk($sformatf("rlast.rd_ready%0d", b), rd_ready, 1'b1);
      chk($sformatf("rlast.error_pre%0d", b), error, 1'b0);
      next_cycle();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    @(negedge clk);
    chk("rlast.finish", rd_burst_finish, 1'b1);
    chk("rlast.error", error, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("rlast.idle", 64'(dut.state_q), 64'(IDLE));
    chk("rlast.sticky", error, 1'b1);
    $display("[TB] early rlast read done, error=%0d", error);
    next_cycle();

    // Address phase stall with m_arready held low
    do_reset();
    rd_valid = 1'b1; rd_burst_len = 10'd1; rd_addr = 32'h4;
    next_cycle();
    rd_valid = 1'b0;
`ifdef MEM_BURST_TIMEOUT_EN
    found = 1'b0; n = 0; err_at_fin = 1'b0;
    for (k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (rd_burst_finish) begin
        found = 1'b1; n = k; err_at_fin = error;
      end
      next_cycle();
    end
    chk("tmo.finish_seen", found, 1'b1);
    chk("tmo.cycles", 64'(n), 64'(TO));
    chk("tmo.error", err_at_fin, 1'b1);
    $display("[TB] timeout abort after %0d cycles", n);
`else
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      chk("stall.arvalid", m_arvalid, 1'b1);
      chk("stall.no_finish", rd_burst_finish, 1'b0);
      next_cycle();
    end
    chk("stall.error", error, 1'b0);
    $display("[TB] stall held for %0d cycles", k);
`endif

    // Reset during WR_DATA beat 2
    do_reset();
    wr_valid = 1'b1; wr_burst_len = 10'd4; wr_addr = 32'h10;
    m_awready = 1'b1; m_wready = 1'b1;
    next_cycle();
    wr_valid = 1'b0;
    next_cycle();
    for (int b = 1; b <= 2; b++) begin
      @(negedge clk);
      chk($sformatf("rstmid.wr_ready%0d", b), wr_ready, 1'b1);
      if (b == 2) rst = 1'b1;
      else next_cycle();
    end
    next_cycle();
    @(negedge clk);
    chk_quiet("rstmid");
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rstmid.no_finish", wr_burst_finish, 1'b0);
      chk("rstmid.no_wvalid", m_wvalid, 1'b0);
      next_cycle();
    end
    $display("[TB] reset mid-write checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
